// File: rtl/mvm_job_arbiter.sv
// mvm_job_arbiter
//   Round-robin arbiter that hands one matrix-vector multiply job at a time
//   from NREQ requesters to a single shared multiplier and returns the
//   result to the job's owner.
//
//   Optional feature: define MVM_ARB_TIMEOUT_EN to build a WAIT watchdog.
//   After TIMEOUT cycles in WAIT without mvm_done, the owner receives an
//   error response (rsp_err=1, rsp_data=0). Without the macro there is no
//   counter, rsp_err is tied low and WAIT lasts until mvm_done.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req                   per-requester job request level
//   req_matrix/req_vector per-requester operands (slice r at r*N*N*WIDTH / r*N*WIDTH)
//   gnt                   one-hot one-cycle grant pulse
//   rsp_valid             one-hot result valid, held until rsp_ack[owner]
//   rsp_data, rsp_err     result vector and timeout flag (qualified by rsp_valid)
//   rsp_ack               per-requester acknowledge
//   busy                  high whenever the FSM is not IDLE
//   mvm_ena               one-cycle start pulse to the multiplier
//   mvm_matrix/mvm_vector multiplier operands, stable for the whole job
//   mvm_result, mvm_done  multiplier result and its one-cycle done pulse
module mvm_job_arbiter #(
   parameter int NREQ    = 4,
   parameter int N       = 3,
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*N*N*WIDTH-1:0] req_matrix,
   input  logic [NREQ*N*WIDTH-1:0]   req_vector,
   output logic [NREQ-1:0]           gnt,
   output logic [NREQ-1:0]           rsp_valid,
   output logic [N*WIDTH-1:0]        rsp_data,
   output logic                      rsp_err,
   input  logic [NREQ-1:0]           rsp_ack,
   output logic                      busy,
   output logic                      mvm_ena,
   output logic [N*N*WIDTH-1:0]      mvm_matrix,
   output logic [N*WIDTH-1:0]        mvm_vector,
   input  logic [N*WIDTH-1:0]        mvm_result,
   input  logic                      mvm_done
);

   localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int MW = N*N*WIDTH;
   localparam int VW = N*WIDTH;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state, state_n;
   logic [OW-1:0]   owner, last_owner, winner;
   logic            any_req;
   logic            tmo;

   function automatic logic [OW-1:0] rr_idx(input logic [OW-1:0] base, input int off);
      return OW'((int'(base) + off) % NREQ);
   endfunction

   // Walk from the farthest candidate back to the nearest so the nearest
   // requesting index after last_owner ends up as the winner.
   always_comb begin
      winner = last_owner;
      for (int i = NREQ; i >= 1; i--)
         if (req[rr_idx(last_owner, i)]) winner = rr_idx(last_owner, i);
   end

   assign any_req = |req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      mvm_ena = 1'b0;
      busy    = (state != IDLE);
      case (state)
         IDLE:  if (any_req) state_n = ISSUE;
         ISSUE: begin
            mvm_ena = 1'b1;
            state_n = WAIT;
         end
         WAIT:  if (mvm_done || tmo) state_n = RESP;
         RESP:  if (rsp_ack[owner]) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Operands are only reloaded on a grant, so they stay put through ISSUE
   // and WAIT while the multiplier works on them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt        <= '0;
         rsp_valid  <= '0;
         rsp_data   <= '0;
         owner      <= '0;
         last_owner <= OW'(NREQ-1);
         mvm_matrix <= '0;
         mvm_vector <= '0;
      end else begin
         gnt <= '0;
         case (state)
            IDLE: if (any_req) begin
               owner      <= winner;
               gnt        <= NREQ'(1) << winner;
               mvm_matrix <= req_matrix[int'(winner)*MW +: MW];
               mvm_vector <= req_vector[int'(winner)*VW +: VW];
            end
            WAIT: if (mvm_done) begin
               rsp_data  <= mvm_result;
               rsp_valid <= NREQ'(1) << owner;
            end else if (tmo) begin
               rsp_data  <= '0;
               rsp_valid <= NREQ'(1) << owner;
            end
            RESP: if (rsp_ack[owner]) begin
               rsp_valid  <= '0;
               last_owner <= owner;
            end
            default: ;
         endcase
      end
   end

`ifdef MVM_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT+1);
   logic [CW-1:0] wd_cnt;
   logic          err_q;

   // Fires in the TIMEOUT-th WAIT cycle, i.e. as the count reaches TIMEOUT.
   assign tmo     = (state == WAIT) && (wd_cnt == CW'(TIMEOUT-1));
   assign rsp_err = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         if (state == ISSUE)              wd_cnt <= '0;
         else if (state == WAIT && !tmo)  wd_cnt <= wd_cnt + 1'b1;
         // mvm_done takes priority over a coincident timeout
         if (state == WAIT) begin
            if (mvm_done) err_q <= 1'b0;
            else if (tmo) err_q <= 1'b1;
         end
      end
   end
`else
   assign tmo     = 1'b0;
   assign rsp_err = 1'b0;
`endif

endmodule

// File: doc/mvm_job_arbiter.md
MVM_JOB_ARBITER -- requirements
Module: mvm_job_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning): NREQ, 4, number of requesters (2..8).
REQ-002 Parameter N, 3: matrix/vector dimension passed to the shared multiplier.
REQ-003 Parameter WIDTH, 8: element bit-width.
REQ-004 Parameter TIMEOUT, 64: watchdog limit in cycles, used only when MVM_ARB_TIMEOUT_EN is defined.
REQ-005 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- req, in, NREQ: per-requester job request level.
- req_matrix, in, NREQ*N*N*WIDTH: per-requester matrix; slice r at r*N*N*WIDTH.
- req_vector, in, NREQ*N*WIDTH: per-requester vector; slice r at r*N*WIDTH.
- gnt, out, NREQ: one-hot, one-cycle grant pulse.
- rsp_valid, out, NREQ: one-hot result-valid, held until acknowledged.
- rsp_data, out, N*WIDTH: result vector.
- rsp_err, out, 1: timeout flag, qualified by rsp_valid.
- rsp_ack, in, NREQ: per-requester result acknowledge.
- busy, out, 1: high in any state other than IDLE.
- mvm_ena, out, 1: start pulse to the multiplier.
- mvm_matrix, out, N*N*WIDTH: multiplier matrix operand.
- mvm_vector, out, N*WIDTH: multiplier vector operand.
- mvm_result, in, N*WIDTH: multiplier result.
- mvm_done, in, 1: multiplier one-cycle done pulse; mvm_result is valid in the same cycle.

Function
REQ-006 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and RESP.
REQ-007 In IDLE with any req bit set, the block SHALL register the round-robin winner into owner, pulse gnt[owner], latch that requester's operands into mvm_matrix/mvm_vector, and go to ISSUE on the same edge.
REQ-008 Round-robin SHALL search from index (last_owner+1) mod NREQ upward with wrap-around; last_owner SHALL reset to NREQ-1 so that requester 0 wins first.
REQ-009 In ISSUE, mvm_ena SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT.
REQ-010 mvm_matrix and mvm_vector SHALL be held constant from the grant edge until the FSM leaves WAIT, so the multiplier's load cycle samples stable data.
REQ-011 mvm_ena SHALL be 0 in all states other than ISSUE.
REQ-012 In WAIT, on mvm_done=1 the block SHALL capture mvm_result into rsp_data, set rsp_valid[owner]=1 and rsp_err=0, and go to RESP.
REQ-013 In RESP, rsp_valid[owner] and rsp_data SHALL be held until rsp_ack[owner]=1; on that edge rsp_valid SHALL clear, last_owner SHALL be updated to owner, and the FSM SHALL go to IDLE.
REQ-014 rsp_ack bits of non-owners, and rsp_ack in non-RESP states, SHALL be ignored.
REQ-015 mvm_done outside WAIT SHALL be ignored.
REQ-016 Once granted, a job SHALL NOT be preempted; req changes during ISSUE/WAIT/RESP SHALL have no effect until IDLE.
REQ-017 The minimum gap between consecutive grants SHALL be one IDLE cycle, i.e. at most one job is in flight.
REQ-018 Latency from gnt to rsp_valid SHALL equal the multiplier latency plus 2 cycles: ISSUE plus capture.
REQ-019 rsp_data SHALL be passed through unmodified, with no width change.

Reset
REQ-020 On rst_n=0, asynchronously: state=IDLE; gnt, rsp_valid, rsp_err, mvm_ena, busy, rsp_data, mvm_matrix and mvm_vector =0; last_owner=NREQ-1; watchdog counter =0.
REQ-021 Reset mid-job SHALL abandon the job without any rsp_valid; a mvm_done arriving after reset release SHALL be ignored per REQ-015.

Configuration
REQ-022 With macro MVM_ARB_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-023 If that counter reaches TIMEOUT without mvm_done, the block SHALL set rsp_valid[owner]=1, rsp_err=1 and rsp_data=0, then go to RESP.
REQ-024 If mvm_done and the timeout occur in the same cycle, mvm_done SHALL win.
REQ-025 Without MVM_ARB_TIMEOUT_EN, no counter SHALL be built, rsp_err SHALL be tied to 0, and WAIT SHALL last indefinitely.

Verification
REQ-026 Single job, NREQ=4, N=3, WIDTH=8: req=0001, A=identity, b=(1,2,3) -> gnt=0001; one mvm_ena pulse; rsp_valid=0001 with rsp_data=(1,2,3); clears on rsp_ack=0001.
REQ-027 Fairness: req=1111 held for 4 jobs, each acked immediately -> grant order 0,1,2,3; then 0 again on a fifth job.
REQ-028 Skip: req=1010 after last_owner=1 -> gnt=1000, then 0010.
REQ-029 Wrong ack: rsp_ack=0100 while owner=0 -> rsp_valid=0001 stays asserted; rsp_ack=0001 clears it.
REQ-030 Timeout, with MVM_ARB_TIMEOUT_EN and TIMEOUT=8: mvm_done tied 0 -> 8 cycles into WAIT, rsp_valid[owner]=1, rsp_err=1, rsp_data=0.
REQ-031 Reset mid-WAIT: rst_n low for 1 cycle, then a mvm_done pulse -> all outputs 0, state IDLE, no rsp_valid.
